// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline stage: valid/ready handshake, optional 2-entry skid buffer,
// flush/squash, and MIPS field decode of the head instruction.
module if_id_pipe_stage #(
    parameter int unsigned         PC_W      = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [PC_W-1:0]     RESET_PC  = 32'h8000_0000,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0000,
    parameter bit                  SKID      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm16,
    output logic [25:0]        jt,
    output logic [1:0]         occupancy
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    logic               in_ready_q;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               push;
    logic               pop;

    // With the skid buffer, ready is a flop so out_ready never reaches in_ready combinationally.
    assign in_ready = SKID ? in_ready_q : (out_ready | ~out_valid);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Head/skid storage and occupancy tracking; reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            occupancy  <= OCC_W'(0);
            out_pc     <= RESET_PC;
            out_instr  <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            // Same-cycle push is dropped; a same-cycle pop is already consumed by decode.
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            occupancy  <= OCC_W'(0);
            out_instr  <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state     <= ST_MAIN;
                        out_valid <= 1'b1;
                        occupancy <= OCC_W'(1);
                        out_pc    <= in_pc;
                        out_instr <= in_instr;
                    end
                    in_ready_q <= 1'b1;
                end
                ST_MAIN: begin
                    if (push && pop) begin
                        out_pc    <= in_pc;
                        out_instr <= in_instr;
                    end else if (push && SKID) begin
                        // Decode stalled: park the new entry behind the head.
                        state      <= ST_FULL;
                        occupancy  <= OCC_W'(2);
                        skid_pc    <= in_pc;
                        skid_instr <= in_instr;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        // Drained: present a NOP so decode never acts on stale bits.
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        occupancy <= OCC_W'(0);
                        out_instr <= NOP_INSTR;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state      <= ST_MAIN;
                        occupancy  <= OCC_W'(1);
                        out_pc     <= skid_pc;
                        out_instr  <= skid_instr;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    out_valid  <= 1'b0;
                    occupancy  <= OCC_W'(0);
                    out_instr  <= NOP_INSTR;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // MIPS field split of the head instruction.
    assign opcode = out_instr[31:26];
    assign rs     = out_instr[25:21];
    assign rt     = out_instr[20:16];
    assign rd     = out_instr[15:11];
    assign shamt  = out_instr[10:6];
    assign funct  = out_instr[5:0];
    assign imm16  = out_instr[15:0];
    assign jt     = out_instr[25:0];

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: scoreboard-checked skid build plus directed SKID=0 checks.
module tb_if_id_pipe_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jt;
    logic [1:0]  occupancy;

    logic        v0 = 1'b0;
    logic        in_ready0;
    logic [31:0] pc0 = '0;
    logic [31:0] ins0 = '0;
    logic        out_valid0;
    logic        ordy0 = 1'b0;
    logic [31:0] out_pc0;
    logic [31:0] out_instr0;
    logic [5:0]  opcode0;
    logic [4:0]  rs0, rt0, rd0, shamt0;
    logic [5:0]  funct0;
    logic [15:0] imm16_0;
    logic [25:0] jt0;
    logic [1:0]  occupancy0;

    item_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    pops  = 0;

    always #5 clk = ~clk;

    if_id_pipe_stage #(.SKID(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .jt(jt), .occupancy(occupancy)
    );

    if_id_pipe_stage #(.SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(v0), .in_ready(in_ready0), .in_pc(pc0), .in_instr(ins0),
        .out_valid(out_valid0), .out_ready(ordy0), .out_pc(out_pc0), .out_instr(out_instr0),
        .opcode(opcode0), .rs(rs0), .rt(rt0), .rd(rd0), .shamt(shamt0), .funct(funct0),
        .imm16(imm16_0), .jt(jt0), .occupancy(occupancy0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one fetch; record expectation on the cycle the handshake fires.
    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (reset && !flush && in_ready) begin
                q.push_back('{pc: pc, instr: ins});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: pc 0x%0h never accepted", pc);
        end
    endtask

    // Monitor: every pop on the skid instance must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got pc 0x%0h instr 0x%0h expected nothing", out_pc, out_instr);
                end else begin
                    item_t e;
                    e = q.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(e.pc));
                    check("sb_instr", 64'(out_instr), 64'(e.instr));
                    pops++;
                end
            end
            if (flush) q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'h8000_0000);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst0_occupancy", 64'(occupancy0), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 2: streaming with field decode
        out_ready = 1'b1;
        send(32'h4, 32'h012A_4020);
        check("str_a_valid", 64'(out_valid), 64'd1);
        check("str_a_pc", 64'(out_pc), 64'h4);
        check("str_rs", 64'(rs), 64'd9);
        check("str_rt", 64'(rt), 64'd10);
        check("str_rd", 64'(rd), 64'd8);
        check("str_funct", 64'(funct), 64'h20);
        check("str_opcode", 64'(opcode), 64'h0);
        send(32'h8, 32'h8D09_0004);
        check("str_b_pc", 64'(out_pc), 64'h8);
        check("str_b_opcode", 64'(opcode), 64'h23);
        check("str_b_imm16", 64'(imm16), 64'h4);
        check("str_b_jt", 64'(jt), 64'h109_0004);
        @(posedge clk);
        #1;
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_instr", 64'(out_instr), 64'd0);
        check("drain_pc_hold", 64'(out_pc), 64'h8);
        check("drain_occ", 64'(occupancy), 64'd0);

        // 3: stall fills skid, release streams A,B,C in order
        out_ready = 1'b0;
        p0 = pops;
        send(32'h10, 32'h1111_0001);
        send(32'h14, 32'h2222_0002);
        check("stall_occ", 64'(occupancy), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        fork
            send(32'h18, 32'h3333_0003);
            begin
                repeat (2) @(posedge clk);
                #2;
                check("stall_hold_pc", 64'(out_pc), 64'h10);
                check("stall_hold_instr", 64'(out_instr), 64'h1111_0001);
                check("stall_hold_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("stall_pops", 64'(pops - p0), 64'd3);
        check("stall_sb_empty", 64'(q.size()), 64'd0);
        check("stall_end_occ", 64'(occupancy), 64'd0);

        // 4a: flush at FULL with a pending input
        out_ready = 1'b0;
        send(32'h20, 32'hAAAA_0001);
        send(32'h24, 32'hAAAA_0002);
        in_valid = 1'b1;
        in_pc    = 32'h28;
        in_instr = 32'hAAAA_0003;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flushF_valid", 64'(out_valid), 64'd0);
        check("flushF_occ", 64'(occupancy), 64'd0);
        check("flushF_instr", 64'(out_instr), 64'd0);
        check("flushF_pc_hold", 64'(out_pc), 64'h20);
        check("flushF_in_ready", 64'(in_ready), 64'd1);

        // 4b: flush at MAIN with an acceptable push, which must be discarded
        send(32'h30, 32'hBBBB_0001);
        in_valid = 1'b1;
        in_pc    = 32'h34;
        in_instr = 32'hBBBB_0002;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flushM_valid", 64'(out_valid), 64'd0);
        check("flushM_occ", 64'(occupancy), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_ghost", 64'(out_valid), 64'd0);

        // 5: reset with two entries held
        out_ready = 1'b0;
        send(32'h40, 32'hCCCC_0001);
        send(32'h44, 32'hCCCC_0002);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_pc", 64'(out_pc), 64'h8000_0000);
        check("mid_rst_instr", 64'(out_instr), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_out", 64'(out_valid), 64'd0);

        // 6: single-entry build, combinational ready and push/pop reload
        ordy0 = 1'b0;
        v0    = 1'b1;
        pc0   = 32'h50;
        ins0  = 32'hDDDD_0001;
        #1;
        check("s0_ready_empty", 64'(in_ready0), 64'd1);
        @(posedge clk);
        #1;
        pc0  = 32'h54;
        ins0 = 32'hDDDD_0002;
        #1;
        check("s0_valid", 64'(out_valid0), 64'd1);
        check("s0_ready_stall", 64'(in_ready0), 64'd0);
        @(posedge clk);
        #1;
        check("s0_hold_pc", 64'(out_pc0), 64'h50);
        ordy0 = 1'b1;
        #1;
        check("s0_ready_comb", 64'(in_ready0), 64'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        check("s0_reload_pc", 64'(out_pc0), 64'h54);
        check("s0_reload_instr", 64'(out_instr0), 64'hDDDD_0002);
        check("s0_reload_occ", 64'(occupancy0), 64'd1);
        @(posedge clk);
        #1;
        check("s0_drain_valid", 64'(out_valid0), 64'd0);
        check("s0_drain_instr", 64'(out_instr0), 64'd0);
        check("s0_drain_occ", 64'(occupancy0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
